// File: rtl/overlay_loader_if.sv
// Overlay feeder bus: job command, instruction/data input streams
// and the overlay-side strobes, bundled for the loader and its driver.
interface overlay_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter int CNT_W      = 16
);
    logic                    start;
    logic [CNT_W-1:0]        num_inst;
    logic [CNT_W-1:0]        num_ld;
    logic [CNT_W-1:0]        num_run;
    logic                    s_inst_v;
    logic [INST_WIDTH-1:0]   s_inst;
    logic                    s_inst_rdy;
    logic                    s_data_v;
    logic [2*DATA_WIDTH-1:0] s_data;
    logic                    s_data_rdy;
    logic                    inst_v;
    logic [INST_WIDTH-1:0]   inst_in;
    logic                    din_v;
    logic [2*DATA_WIDTH-1:0] din_ld;
    logic [2*DATA_WIDTH-1:0] din_pe;
    logic                    busy;
    logic                    done;

    modport slave (
        input  start, num_inst, num_ld, num_run,
        input  s_inst_v, s_inst, s_data_v, s_data,
        output s_inst_rdy, s_data_rdy,
        output inst_v, inst_in, din_v, din_ld, din_pe,
        output busy, done
    );

    modport master (
        output start, num_inst, num_ld, num_run,
        output s_inst_v, s_inst, s_data_v, s_data,
        input  s_inst_rdy, s_data_rdy,
        input  inst_v, inst_in, din_v, din_ld, din_pe,
        input  busy, done
    );
endinterface

// File: rtl/overlay_loader.sv
// Overlay feeder: sequences instruction, PE-load and run-time streams
// for one job per start, with one-cycle registered output latency.
module overlay_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst,
    overlay_loader_if.slave bus
);
    localparam int DW = 2 * DATA_WIDTH;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, INST, LOAD, RUN} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      ci_q, ci_d;
    logic [CNT_W-1:0]      cl_q, cl_d;
    logic [CNT_W-1:0]      cr_q, cr_d;
    logic                  inst_v_q, inst_v_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  din_v_q, din_v_d;
    logic [DW-1:0]         ld_q, ld_d;
    logic [DW-1:0]         pe_q, pe_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ci_q     <= '0;
            cl_q     <= '0;
            cr_q     <= '0;
            inst_v_q <= 1'b0;
            inst_q   <= '0;
            din_v_q  <= 1'b0;
            ld_q     <= '0;
            pe_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ci_q     <= ci_d;
            cl_q     <= cl_d;
            cr_q     <= cr_d;
            inst_v_q <= inst_v_d;
            inst_q   <= inst_d;
            din_v_q  <= din_v_d;
            ld_q     <= ld_d;
            pe_q     <= pe_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ci_d     = ci_q;
        cl_d     = cl_q;
        cr_d     = cr_q;
        inst_v_d = 1'b0;
        inst_d   = inst_q;
        din_v_d  = 1'b0;
        ld_d     = ld_q;
        pe_d     = pe_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ci_d = bus.num_inst;
                    cl_d = bus.num_ld;
                    cr_d = bus.num_run;
                    if (bus.num_inst != '0)    state_d = INST;
                    else if (bus.num_ld != '0) state_d = LOAD;
                    else if (bus.num_run != '0) state_d = RUN;
                    else done_d = 1'b1;
                end
            end
            INST: begin
                if (bus.s_inst_v) begin
                    inst_v_d = 1'b1;
                    inst_d   = bus.s_inst;
                    ci_d     = ci_q - ONE;
                    if (ci_q == ONE) begin
                        if (cl_q != '0)      state_d = LOAD;
                        else if (cr_q != '0) state_d = RUN;
                        else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            LOAD: begin
                if (bus.s_data_v) begin
                    din_v_d = 1'b1;
                    ld_d    = bus.s_data;
                    cl_d    = cl_q - ONE;
                    if (cl_q == ONE) begin
                        if (cr_q != '0) state_d = RUN;
                        else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                if (bus.s_data_v) begin
                    din_v_d = 1'b1;
                    pe_d    = bus.s_data;
                    cr_d    = cr_q - ONE;
                    if (cr_q == ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // run-time lane reads zero whenever the overlay is in its load phase
        if (state_q == LOAD || state_d == LOAD) pe_d = '0;
    end

    assign bus.s_inst_rdy = (state_q == INST);
    assign bus.s_data_rdy = (state_q == LOAD) || (state_q == RUN);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.inst_v     = inst_v_q;
    assign bus.inst_in    = inst_q;
    assign bus.din_v      = din_v_q;
    assign bus.din_ld     = ld_q;
    assign bus.din_pe     = pe_q;
endmodule
